hog_block_assembler: RTL and testbench
======================================

// Module: hog_block_assembler
// PURPOSE
//  Streams per-cell HOG histograms in raster order, CELLS_X cells/row, CELLS_Y rows/frame.
//  Emits every overlapping 2x2 cell block (a=upper-left, b=upper-right, c=lower-left,
//  d=lower-right) to the downstream normalize stage over a valid/ready handshake.
//  Generalises the fixed-width, fixed-depth feature generator: bins, widths and frame
//  geometry are parameters, backpressure is supported, and frame end is flagged.
// PARAMETERS
//  NBIN     9    histogram bins per cell
//  BIN_W    32   bits per bin (unsigned fixed point, format passed through)
//  CELLS_X  40   cells per row (>=2)
//  CELLS_Y  30   rows per frame (>=2)
//  CELL_W   derived, NBIN*BIN_W
// PORTS
//  clk        in   1           clock
//  rst        in   1           synchronous reset, active-high
//  in_valid   in   1           cell histogram valid
//  in_ready   out  1           block can accept a cell
//  in_sof     in   1           qualifies the first cell of a frame (sampled with in_valid)
//  in_bin     in   CELL_W      cell histogram; bin k at [k*BIN_W +: BIN_W]
//  out_valid  out  1           block valid
//  out_ready  in   1           downstream accepts the block
//  out_eof    out  1           block is the last block of the frame
//  out_a..d   out  CELL_W each four cell histograms of the block
//  out_sum    out  SUM_W       only with HOG_BLOCK_SUM_EN; SUM_W = BIN_W+$clog2(4*NBIN)
// BEHAVIOUR
//  - Reset: out_valid=0, out_eof=0, out_a..d=0, out_sum=0, col=0, row=0; in_ready=1 one cycle after reset.
//    Line-buffer contents are not cleared (never read before being rewritten).
//  - Accept when in_valid & in_ready; in_ready = !out_valid | out_ready (single output register).
//  - Counters col (0..CELLS_X-1), row (0..CELLS_Y-1) point at the accepted cell. Accept with
//    in_sof=1 forces position (0,0) for that cell regardless of counter state (mid-frame
//    restart: partial frame dropped, no block from it is emitted after the restart).
//  - Line buffer: CELLS_X-entry array of CELL_W. On accept at col: read entry[col] (previous
//    row) then write in_bin to entry[col]. Registers hold upper-left = previous read and
//    lower-left = previous accepted cell.
//  - Block emitted on an accepted cell when row>=1 and col>=1:
//    a=prev-row[col-1], b=prev-row[col], c=cur-row[col-1], d=in_bin.
//    Latency 1 cycle: out_valid rises the cycle after acceptance. Row 0 and col 0 cells
//    emit nothing. Blocks per frame = (CELLS_X-1)*(CELLS_Y-1).
//  - out_valid & !out_ready: all outputs held stable, in_ready=0. Same-cycle
//    out_ready and new accept: register reloads, no bubble (full throughput 1 block/cycle).
//  - Wrap: col==CELLS_X-1 -> col=0,row+1. row==CELLS_Y-1 & col==CELLS_X-1 -> out_eof=1
//    on that block, counters return to (0,0); the next cell starts a new frame even
//    without in_sof.
//  - in_sof=1 without in_valid is ignored. in_valid while in_ready=0: input must hold (not consumed).
//  - rst asserted mid-frame: outputs and counters to reset values next edge, pending block lost.
// CONFIGURATION
//  HOG_BLOCK_SUM_EN defined: out_sum port exists; out_sum = unsigned sum of all 4*NBIN bins
//    of the emitted block, registered with the block (same latency, no overflow at SUM_W),
//    held under backpressure, 0 on reset. Feeds the L1 normaliser.
//  Not defined: out_sum port and adder tree absent; all other behaviour identical.
// TESTING (CELLS_X=4, CELLS_Y=3, NBIN=9, BIN_W=16)
//  1. Reset, feed 12 cells, each bin = cell index (0..11), in_sof on cell 0, out_ready=1
//     -> 6 blocks; first has a..d bins 0,1,4,5; last 6,7,10,11 with out_eof=1, others out_eof=0.
//  2. Same stream with out_ready low for 3 cycles at block 2 -> block 2 held unchanged,
//     in_ready=0 during stall, no block lost or duplicated, order preserved.
//  3. in_sof asserted on cell 7 of a frame, then 12 cells -> no block from old data;
//     next 6 blocks match scenario 1 with the new values.
//  4. Two back-to-back frames without in_sof on frame 2 -> 12 blocks, out_eof on 6th and 12th.
//  5. rst high for 1 cycle after cell 6 -> out_valid=0 next cycle; new frame yields correct 6 blocks.
//  6. HOG_BLOCK_SUM_EN, all bins 16'hFFFF -> out_sum = 36*65535 = 2359260, no overflow.

Source files
------------

// File: rtl/hog_block_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hog_block_assembler                                              |
// | Purpose : streams raster-order HOG cell histograms and emits every         |
// |           overlapping 2x2 cell block over a valid/ready handshake.         |
// | Option  : HOG_BLOCK_SUM_EN adds out_sum, the L1 sum of the block's bins.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module hog_block_assembler #(
  parameter  int NBIN    = 9,
  parameter  int BIN_W   = 32,
  parameter  int CELLS_X = 40,
  parameter  int CELLS_Y = 30,
  localparam int CELL_W  = NBIN * BIN_W,
  localparam int SUM_W   = BIN_W + $clog2(4 * NBIN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [CELL_W-1:0] in_bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_eof,
  output logic [CELL_W-1:0] out_a,
  output logic [CELL_W-1:0] out_b,
  output logic [CELL_W-1:0] out_c,
  output logic [CELL_W-1:0] out_d
`ifdef HOG_BLOCK_SUM_EN
  ,
  output logic [SUM_W-1:0]  out_sum
`endif
);

  localparam int COL_W = $clog2(CELLS_X);
  localparam int ROW_W = $clog2(CELLS_Y);
  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(CELLS_X - 1);
  localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(CELLS_Y - 1);

  logic [CELL_W-1:0] line_q [CELLS_X];
  logic [CELL_W-1:0] ul_q;
  logic [CELL_W-1:0] ll_q;
  logic [CELL_W-1:0] up_rd_w;

  logic [COL_W-1:0]  col_q, col_d, col_cur_w;
  logic [ROW_W-1:0]  row_q, row_d, row_cur_w;
  logic              accept_w, emit_w, last_w;

  logic              valid_q, valid_d;
  logic              eof_q, eof_d;
  logic [CELL_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;

  // in_sof overrides the counters so a restart lands at (0,0) immediately
  always_comb begin
    in_ready  = !valid_q || out_ready;
    accept_w  = in_valid && in_ready;
    col_cur_w = in_sof ? '0 : col_q;
    row_cur_w = in_sof ? '0 : row_q;
    up_rd_w   = line_q[col_cur_w];
    emit_w    = accept_w && (row_cur_w != '0) && (col_cur_w != '0);
    last_w    = (row_cur_w == C_ROW_LAST) && (col_cur_w == C_COL_LAST);
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = valid_q;
    eof_d   = eof_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    if (accept_w) begin
      if (col_cur_w == C_COL_LAST) begin
        col_d = '0;
        row_d = (row_cur_w == C_ROW_LAST) ? '0 : row_cur_w + 1'b1;
      end else begin
        col_d = col_cur_w + 1'b1;
        row_d = row_cur_w;
      end
    end
    if (emit_w) begin
      valid_d = 1'b1;
      eof_d   = last_w;
      a_d     = ul_q;
      b_d     = up_rd_w;
      c_d     = ll_q;
      d_d     = in_bin;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      eof_q   <= eof_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end

  // Datapath storage needs no reset: every entry is rewritten before it is read
  always_ff @(posedge clk) begin
    if (accept_w) begin
      line_q[col_cur_w] <= in_bin;
      ul_q              <= up_rd_w;
      ll_q              <= in_bin;
    end
  end

  assign out_valid = valid_q;
  assign out_eof   = eof_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_c     = c_q;
  assign out_d     = d_q;

`ifdef HOG_BLOCK_SUM_EN
  logic [SUM_W-1:0] sum_q, sum_d, sum_w;

  always_comb begin
    sum_w = '0;
    for (int k = 0; k < NBIN; k++) begin
      sum_w = sum_w + SUM_W'(ul_q[k*BIN_W +: BIN_W]) + SUM_W'(up_rd_w[k*BIN_W +: BIN_W])
                    + SUM_W'(ll_q[k*BIN_W +: BIN_W]) + SUM_W'(in_bin[k*BIN_W +: BIN_W]);
    end
    sum_d = emit_w ? sum_w : sum_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign out_sum = sum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hog_block_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_hog_block_assembler                                           |
// | Purpose : self-checking bench for hog_block_assembler (4x3 cells, 9x16b).  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_hog_block_assembler;

  localparam int NBIN    = 9;
  localparam int BIN_W   = 16;
  localparam int CELLS_X = 4;
  localparam int CELLS_Y = 3;
  localparam int CELL_W  = NBIN * BIN_W;
  localparam int SUM_W   = BIN_W + $clog2(4 * NBIN);
  localparam int CW      = 640;

  typedef struct packed {
    logic [CELL_W-1:0] a;
    logic [CELL_W-1:0] b;
    logic [CELL_W-1:0] c;
    logic [CELL_W-1:0] d;
    logic              eof;
  } blk_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_sof;
  logic [CELL_W-1:0] in_bin;
  logic              out_valid, out_ready, out_eof;
  logic [CELL_W-1:0] out_a, out_b, out_c, out_d;
`ifdef HOG_BLOCK_SUM_EN
  logic [SUM_W-1:0]  out_sum;
  longint            last_sum;
`endif

  int     n_cmp = 0;
  int     n_bad = 0;
  int     n_pop = 0;
  int     n_eof = 0;
  int     stall_base = 0;
  int     stall_done = 0;
  bit     stall_arm = 1'b0;
  bit     rnd_rdy = 1'b0;
  bit     held_v = 1'b0;
  blk_t   held;
  blk_t   mon_e;
  blk_t   expq[$];
  logic [CELL_W-1:0] grid [CELLS_Y][CELLS_X];
  int     mrow = 0;
  int     mcol = 0;

  hog_block_assembler #(
    .NBIN(NBIN), .BIN_W(BIN_W), .CELLS_X(CELLS_X), .CELLS_Y(CELLS_Y)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready), .out_eof(out_eof),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d)
`ifdef HOG_BLOCK_SUM_EN
    , .out_sum(out_sum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CELL_W-1:0] cell_all(input int v);
    logic [CELL_W-1:0] r;
    for (int k = 0; k < NBIN; k++) r[k*BIN_W +: BIN_W] = BIN_W'(v);
    return r;
  endfunction

  function automatic logic [CELL_W-1:0] cell_rnd();
    logic [CELL_W-1:0] r;
    for (int k = 0; k < NBIN; k++) r[k*BIN_W +: BIN_W] = BIN_W'($urandom);
    return r;
  endfunction

  function automatic longint bsum(input blk_t e);
    longint s = 0;
    for (int k = 0; k < NBIN; k++)
      s = s + longint'(e.a[k*BIN_W +: BIN_W]) + longint'(e.b[k*BIN_W +: BIN_W])
            + longint'(e.c[k*BIN_W +: BIN_W]) + longint'(e.d[k*BIN_W +: BIN_W]);
    return s;
  endfunction

  // Reference: cells land in a 2D frame grid; a block is the 2x2 window ending at the new cell
  task automatic model_accept(input logic sof, input logic [CELL_W-1:0] v);
    int   r, c;
    blk_t e;
    if (sof) begin
      mrow = 0;
      mcol = 0;
    end
    r = mrow;
    c = mcol;
    grid[r][c] = v;
    if (r >= 1 && c >= 1) begin
      e.a   = grid[r-1][c-1];
      e.b   = grid[r-1][c];
      e.c   = grid[r][c-1];
      e.d   = v;
      e.eof = (r == CELLS_Y - 1) && (c == CELLS_X - 1);
      expq.push_back(e);
    end
    mcol = c + 1;
    if (mcol == CELLS_X) begin
      mcol = 0;
      mrow = (r + 1 == CELLS_Y) ? 0 : r + 1;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      mrow   = 0;
      mcol   = 0;
      held_v = 1'b0;
    end else begin
      chk("in_ready", CW'(in_ready), CW'(!out_valid || out_ready));
      chk("out_valid", CW'(out_valid), CW'(expq.size() != 0));
      if (out_valid && held_v)
        chk("hold", CW'({out_a, out_b, out_c, out_d, out_eof}), CW'(held));
      held_v = out_valid && !out_ready;
      held   = {out_a, out_b, out_c, out_d, out_eof};
      if (out_valid && out_ready && expq.size() != 0) begin
        mon_e = expq.pop_front();
        chk("blk_abcd", CW'({out_a, out_b, out_c, out_d}), CW'({mon_e.a, mon_e.b, mon_e.c, mon_e.d}));
        chk("blk_eof", CW'(out_eof), CW'(mon_e.eof));
`ifdef HOG_BLOCK_SUM_EN
        chk("blk_sum", CW'(out_sum), CW'(bsum(mon_e)));
        last_sum = longint'(out_sum);
`endif
        n_pop++;
        if (out_eof) n_eof++;
      end
      if (in_valid && in_ready) model_accept(in_sof, in_bin);
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_arm && (n_pop - stall_base == 1) && out_valid && stall_done < 3) begin
        out_ready  = 1'b0;
        stall_done = stall_done + 1;
      end else begin
        out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic sof, input logic [CELL_W-1:0] v);
    int w = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_bin   = v;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", CW'(in_ready), CW'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  int base_pop, base_eof;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_bin = '0;
    idle(3);
    rst = 1'b0;
    chk("rst_valid", CW'(out_valid), CW'(0));
    chk("rst_eof", CW'(out_eof), CW'(0));
    chk("rst_abcd", CW'({out_a, out_b, out_c, out_d}), CW'(0));
    chk("rst_ready", CW'(in_ready), CW'(1));
`ifdef HOG_BLOCK_SUM_EN
    chk("rst_sum", CW'(out_sum), CW'(0));
`endif

    // Scenario 1: single frame, bins equal to cell index
    base_pop = n_pop; base_eof = n_eof;
    for (int i = 0; i < 12; i++) send(i == 0, cell_all(i));
    idle(4);
    chk("s1_blocks", CW'(n_pop - base_pop), CW'(6));
    chk("s1_eofs", CW'(n_eof - base_eof), CW'(1));

    // Scenario 2: stall on the second block
    base_pop = n_pop; stall_base = n_pop; stall_done = 0; stall_arm = 1'b1;
    for (int i = 0; i < 12; i++) send(i == 0, cell_all(20 + i));
    idle(6);
    stall_arm = 1'b0;
    chk("s2_blocks", CW'(n_pop - base_pop), CW'(6));
    chk("s2_stalled", CW'(stall_done), CW'(3));

    // Scenario 3: restart mid-frame on cell 7
    base_pop = n_pop; base_eof = n_eof;
    for (int i = 0; i < 7; i++) send(i == 0, cell_all(40 + i));
    for (int i = 0; i < 12; i++) send(i == 0, cell_all(60 + i));
    idle(4);
    chk("s3_blocks", CW'(n_pop - base_pop), CW'(8));
    chk("s3_eofs", CW'(n_eof - base_eof), CW'(1));

    // Scenario 4: two frames, in_sof only on the first
    base_pop = n_pop; base_eof = n_eof;
    for (int i = 0; i < 24; i++) send(i == 0, cell_all(80 + i));
    idle(4);
    chk("s4_blocks", CW'(n_pop - base_pop), CW'(12));
    chk("s4_eofs", CW'(n_eof - base_eof), CW'(2));

    // Scenario 5: reset mid-frame, then a frame without in_sof
    for (int i = 0; i < 7; i++) send(i == 0, cell_all(120 + i));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("s5_valid_after_rst", CW'(out_valid), CW'(0));
    base_pop = n_pop; base_eof = n_eof;
    for (int i = 0; i < 12; i++) send(1'b0, cell_all(140 + i));
    idle(4);
    chk("s5_blocks", CW'(n_pop - base_pop), CW'(6));
    chk("s5_eofs", CW'(n_eof - base_eof), CW'(1));

    // Scenario 6: saturated bins
    base_pop = n_pop;
    for (int i = 0; i < 12; i++) send(i == 0, cell_all(16'hFFFF));
    idle(4);
    chk("s6_blocks", CW'(n_pop - base_pop), CW'(6));
`ifdef HOG_BLOCK_SUM_EN
    chk("s6_sum", CW'(last_sum), CW'(2359260));
`endif

    // Randomized traffic: random data, gaps, backpressure and occasional restarts
    rnd_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send((i == 0) || ($urandom_range(0, 19) == 0), cell_rnd());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rnd_rdy = 1'b0;
    idle(2);
    for (int w = 0; w < 50 && expq.size() != 0; w++) idle(1);
    chk("drain", CW'(expq.size()), CW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
